// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings, helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  // $clog2 that never returns 0, so a single-register bank still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle (all five channels) with master/slave views.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [1:0]            rresp;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
endinterface

// File: rtl/axi_lite_wr_capture.sv
// Independent AW / W latches for an AXI4-Lite slave; flags when both are held.
module axi_lite_wr_capture #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    busy,      // response outstanding: accept nothing
  input  logic                    consume,   // owner has executed the held write
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    both,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb
);
  logic run_q;    // keeps readys low while in reset and on the first cycle out of it
  logic aw_held;
  logic w_held;

  assign awready = run_q & ~aw_held & ~busy;
  assign wready  = run_q & ~w_held  & ~busy;
  assign both    = aw_held & w_held;

  // Latch each channel on its own handshake; drop both once the write is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr    <= '0;
      data    <= '0;
      strb    <= '0;
    end else begin
      run_q <= 1'b1;
      if (consume) begin
        aw_held <= 1'b0;
      end else if (awvalid && awready) begin
        aw_held <= 1'b1;
        addr    <= awaddr;
      end
      if (consume) begin
        w_held <= 1'b0;
      end else if (wvalid && wready) begin
        w_held <= 1'b1;
        data   <= wdata;
        strb   <= wstrb;
      end
    end
  end
endmodule

// File: rtl/axi_lite_reg_bank.sv
// Parametrised AXI4-Lite register bank: byte-strobed RW registers, live RO status
// slots, SLVERR on out-of-range or read-only writes, per-register access strobes.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
  input  logic                           i_axi_clk,
  input  logic                           i_axi_rst,
  axi_lite_if.slave                      s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro_data,
  output logic [NUM_REGS-1:0]            o_wr_stb,
  output logic [NUM_REGS-1:0]            o_rd_stb
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = clog2_min1(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH+1)'(NUM_REGS * STRB_WIDTH);

  wr_state_e                            wstate;
  rd_state_e                            rstate;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q;

  logic                  cap_both;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [STRB_WIDTH-1:0] cap_strb;
  logic                  consume;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in;
  logic [NUM_REGS-1:0]   wr_hit;

  logic                  ar_hs;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in;
  logic [NUM_REGS-1:0]   rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  axi_lite_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_cap (
    .clk     (i_axi_clk),
    .rst     (i_axi_rst),
    .busy    (s_axi.bvalid),
    .consume (consume),
    .awvalid (s_axi.awvalid),
    .awready (s_axi.awready),
    .awaddr  (s_axi.awaddr),
    .wvalid  (s_axi.wvalid),
    .wready  (s_axi.wready),
    .wdata   (s_axi.wdata),
    .wstrb   (s_axi.wstrb),
    .both    (cap_both),
    .addr    (cap_addr),
    .data    (cap_data),
    .strb    (cap_strb)
  );

  assign consume = cap_both && (wstate == W_IDLE);
  assign wr_idx  = cap_addr[IDX_W+LSB-1:LSB];
  assign wr_in   = {1'b0, cap_addr} < ADDR_LIM;

  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign rd_idx  = s_axi.araddr[IDX_W+LSB-1:LSB];
  assign rd_in   = {1'b0, s_axi.araddr} < ADDR_LIM;

  // One-hot write target; empty for out-of-range or read-only slots.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_hit[i] = consume && wr_in && (wr_idx == IDX_W'(i)) && !RO_MASK[i];
  end

  // Read mux over the pre-write register image, plus the accept-cycle strobe.
  always_comb begin
    rd_hit = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_in && (rd_idx == IDX_W'(i))) begin
        rd_hit[i] = ar_hs;
        rd_val    = RO_MASK[i] ? i_ro_data[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  assign o_wr_stb = wr_hit;
  assign o_rd_stb = rd_hit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign o_regs[gi*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[gi] ? '0 : regs_q[gi];
  end

  // Register array: byte-lane update of the hit register.
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_hit[i])
          for (int b = 0; b < STRB_WIDTH; b++)
            if (cap_strb[b]) regs_q[i][b*8 +: 8] <= cap_data[b*8 +: 8];
    end
  end

  // Write response FSM: execute when AW+W are both held, then hold B until bready.
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      wstate       <= W_IDLE;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: if (consume) begin
          wstate       <= W_RESP;
          s_axi.bvalid <= 1'b1;
          s_axi.bresp  <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: if (s_axi.bready) begin
          wstate       <= W_IDLE;
          s_axi.bvalid <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: accept AR in idle, register data/resp, hold R until rready.
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      rstate        <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rdata   <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (ar_hs) begin
          rstate        <= R_DATA;
          s_axi.arready <= 1'b0;
          s_axi.rvalid  <= 1'b1;
          s_axi.rresp   <= rd_in ? RESP_OKAY : RESP_SLVERR;
          s_axi.rdata   <= rd_val;
        end else begin
          s_axi.arready <= 1'b1;
        end
        R_DATA: if (s_axi.rready) begin
          rstate        <= R_IDLE;
          s_axi.rvalid  <= 1'b0;
          s_axi.arready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Bench for axi_lite_reg_bank: vector table, hand corner cases, random soak vs model.
module tb_axi_lite_reg_bank;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0]    ROM = 16'h8000;
  localparam logic [NR*DW-1:0] RV  = ((NR*DW)'(32'hA5A50003) << (3*DW)) |
                                     ((NR*DW)'(32'h0BADF00D) << (7*DW));

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*DW-1:0] regs;
  logic [NR*DW-1:0] ro_data = '0;
  logic [NR-1:0]   wr_stb, rd_stb;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_reg_bank #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
    .RO_MASK (ROM), .RESET_VALS (RV)
  ) dut (
    .i_axi_clk (clk), .i_axi_rst (rst), .s_axi (bus),
    .o_regs (regs), .i_ro_data (ro_data), .o_wr_stb (wr_stb), .o_rd_stb (rd_stb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor, sampled mid-cycle.
  logic [NR-1:0] wr_acc, rd_acc;
  int            wr_cyc, rd_cyc;
  always @(negedge clk) begin
    if (|wr_stb) begin wr_acc <= wr_acc | wr_stb; wr_cyc <= wr_cyc + 1; end
    if (|rd_stb) begin rd_acc <= rd_acc | rd_stb; rd_cyc <= rd_cyc + 1; end
  end

  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;
  logic [1:0] wq[$];
  rexp_t      rq[$];
  logic [31:0] mdl [NR];

  typedef struct {
    bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
    int d1; int d2; int hold; logic [1:0] resp; logic [31:0] rdata; logic [15:0] stb;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) tick();
    bus.awaddr = a; bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("aw_timeout", 1, 0);
    tick(); bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) tick();
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("w_timeout", 1, 0);
    tick(); bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) tick();
    bus.araddr = a; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("ar_timeout", 1, 0);
    tick(); bus.arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int hold,
                          input logic [1:0] er, input logic [15:0] es);
    int n = 0;
    logic ok;
    logic [1:0] r0, e;
    wq.push_back(er);
    wr_acc = '0; wr_cyc = 0;
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    while (!bus.bvalid && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("b_timeout", 1, 0);
    ok = 1'b1; r0 = bus.bresp;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.bvalid || bus.bresp !== r0 || bus.awready || bus.wready) ok = 1'b0;
    end
    if (hold > 0) chk("b_hold_stable", ok, 1);
    if (wq.size() == 0) chk("wq_empty", 1, 0);
    else begin e = wq.pop_front(); chk("bresp", bus.bresp, e); end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    chk("b_drop", bus.bvalid, 0);
    chk("wr_stb", wr_acc, es);
    chk("wr_stb_cycles", wr_cyc, (es != 0) ? 1 : 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int dly, input int hold,
                         input logic [1:0] er, input logic [31:0] ed, input logic [15:0] es);
    int n = 0;
    logic ok;
    logic [31:0] d0;
    rexp_t x;
    x.resp = er; x.data = ed; rq.push_back(x);
    rd_acc = '0; rd_cyc = 0;
    send_ar(a, dly);
    while (!bus.rvalid && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("r_timeout", 1, 0);
    ok = 1'b1; d0 = bus.rdata;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.rvalid || bus.rdata !== d0 || bus.arready) ok = 1'b0;
    end
    if (hold > 0) chk("r_hold_stable", ok, 1);
    if (rq.size() == 0) chk("rq_empty", 1, 0);
    else begin
      x = rq.pop_front();
      chk("rresp", bus.rresp, x.resp);
      chk("rdata", bus.rdata, x.data);
    end
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    chk("r_drop", bus.rvalid, 0);
    chk("ar_back", bus.arready, 1);
    chk("rd_stb", rd_acc, es);
    chk("rd_stb_cycles", rd_cyc, (es != 0) ? 1 : 0);
  endtask

  function automatic logic [63:0] outs_or();
    return {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
            bus.rresp, wr_stb, rd_stb} | {30'b0, bus.rdata};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, ed;
    logic [3:0]  s;
    logic [3:0]  idx;
    logic        inr;
    logic [1:0]  er;
    logic [15:0] es;
    int          n;

    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    wr_acc = '0; rd_acc = '0; wr_cyc = 0; rd_cyc = 0;

    // Reset at time zero, then a mid-cycle reset after the bus came alive.
    #1;
    chk("reset0_outputs", outs_or(), 0);
    chk("reset0_regs", regs, RV);
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("alive_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    #3 rst = 1'b1;
    #1;
    chk("reset_mid_outputs", outs_or(), 0);
    chk("reset_mid_regs", regs, RV);
    tick(); rst = 1'b0;
    repeat (2) tick();

    ro_data[15*DW +: DW] = 32'hCAFE0001;
    //            wr addr          data          strb  d1 d2 hold resp         rdata         stb
    tbl[0]  = '{1, 32'h08,       32'hDEADBEEF, 4'hF, 0, 3, 0, RESP_OKAY,   32'h0,        16'h0004};
    tbl[1]  = '{0, 32'h08,       32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hDEADBEEF, 16'h0004};
    tbl[2]  = '{1, 32'h08,       32'h11223344, 4'h5, 3, 0, 0, RESP_OKAY,   32'h0,        16'h0004};
    tbl[3]  = '{0, 32'h08,       32'h0,        4'h0, 1, 0, 0, RESP_OKAY,   32'hDE22BE44, 16'h0004};
    tbl[4]  = '{1, 32'h3C,       32'h12345678, 4'hF, 0, 0, 0, RESP_SLVERR, 32'h0,        16'h0000};
    tbl[5]  = '{0, 32'h3C,       32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hCAFE0001, 16'h8000};
    tbl[6]  = '{1, 32'h40,       32'hFFFFFFFF, 4'hF, 0, 0, 5, RESP_SLVERR, 32'h0,        16'h0000};
    tbl[7]  = '{0, 32'h40,       32'h0,        4'h0, 0, 0, 5, RESP_SLVERR, 32'h0,        16'h0000};
    tbl[8]  = '{1, 32'h0C,       32'hFFFFFFFF, 4'h0, 1, 1, 0, RESP_OKAY,   32'h0,        16'h0008};
    tbl[9]  = '{0, 32'h0E,       32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hA5A50003, 16'h0008};
    tbl[10] = '{0, 32'h1C,       32'h0,        4'h0, 2, 0, 1, RESP_OKAY,   32'h0BADF00D, 16'h0080};
    tbl[11] = '{1, 32'h3B,       32'h000000AA, 4'h1, 2, 1, 2, RESP_OKAY,   32'h0,        16'h4000};
    tbl[12] = '{0, 32'h38,       32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'h000000AA, 16'h4000};
    tbl[13] = '{0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 0, 0, RESP_SLVERR, 32'h0,        16'h0000};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].d1, tbl[i].d2, tbl[i].hold,
                 tbl[i].resp, tbl[i].stb);
      else
        do_read(tbl[i].addr, tbl[i].d1, tbl[i].hold, tbl[i].resp, tbl[i].rdata, tbl[i].stb);
    end
    chk("regs_reg2", regs[2*DW +: DW], 32'hDE22BE44);
    chk("regs_reg3", regs[3*DW +: DW], 32'hA5A50003);
    chk("regs_reg14", regs[14*DW +: DW], 32'h000000AA);
    chk("regs_ro_slot", regs[15*DW +: DW], 32'h0);

    // Same-cycle read and write of reg1: read sees the old value, write lands.
    fork
      do_write(32'h04, 32'h5, 4'hF, 0, 0, 0, RESP_OKAY, 16'h0002);
      do_read(32'h04, 1, 0, RESP_OKAY, 32'h0, 16'h0002);
    join
    do_read(32'h04, 0, 0, RESP_OKAY, 32'h5, 16'h0002);

    // Reset with only AW latched: AW must be discarded, no response ever appears.
    send_aw(32'h10, 0);
    #3 rst = 1'b1;
    #1 chk("rst_txn_outputs", outs_or(), 0);
    tick(); rst = 1'b0;
    tick();
    send_w(32'h77777777, 4'hF, 0);
    n = 0;
    repeat (8) begin @(negedge clk); if (bus.bvalid || (|wr_stb)) n++; end
    chk("rst_txn_no_resp", n, 0);
    chk("rst_txn_regs", regs, RV);
    tick(); rst = 1'b1; tick(); rst = 1'b0; repeat (2) tick();

    // Random-stall soak against a reference model.
    for (int i = 0; i < NR; i++) mdl[i] = RV[i*DW +: DW];
    for (int k = 0; k < 1000; k++) begin
      ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a   = $urandom_range(0, 17) * 4 + $urandom_range(0, 3);
      idx = a[5:2];
      inr = (a < 32'h40);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        if (inr && !ROM[idx]) begin
          er = RESP_OKAY; es = 16'h1 << idx;
          for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          er = RESP_SLVERR; es = '0;
        end
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), er, es);
      end else begin
        if (inr) begin
          er = RESP_OKAY; es = 16'h1 << idx;
          ed = ROM[idx] ? ro_data[idx*DW +: DW] : mdl[idx];
        end else begin
          er = RESP_SLVERR; es = '0; ed = '0;
        end
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), er, ed, es);
      end
    end
    for (int i = 0; i < NR; i++)
      chk("soak_regs", regs[i*DW +: DW], ROM[i] ? 32'h0 : mdl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
